// File: rtl/store_pkg.sv
// Shared definitions for the store execution stage.
//   OP_*      : primary opcodes of the store instructions handled here
//   BE_*      : byte-enable patterns before lane shifting
//   acc_e     : decoded access size
//   pack_entry: packs one store-buffer entry as {addr, wdata, be}
package store_pkg;

    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_e;

    // Address occupies the top bits, so a narrower entry is simply the
    // low bits of this value when the address is truncated.
    function automatic logic [67:0] pack_entry(input logic [31:0] addr,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        return {addr, wdata, be};
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store request bus between the store unit and data memory.
// Handshake: the master raises mem_valid with addr/wdata/be; a transfer happens
// on a rising edge where mem_valid && mem_ready. While mem_valid is high and
// mem_ready is low, the master holds every request field stable. mem_ready is
// don't-care while mem_valid is low.
//   master : drives mem_valid, mem_addr, mem_wdata, mem_be; receives mem_ready
//   slave  : the memory side
interface store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_be,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_be,
        output mem_ready
    );
endinterface

// File: rtl/sign_extend.sv
// Sign-extends a 16-bit immediate to 32 bits.
//   imm : 16-bit immediate
//   ext : sign-extended result
module sign_extend (
    input  logic [15:0] imm,
    output logic [31:0] ext
);
    assign ext = {{16{imm[15]}}, imm};
endmodule

// File: rtl/store_fifo.sv
// Circular store buffer with synchronous reset.
//   clk, reset : clock, synchronous active-high reset (empties the buffer)
//   push/wdata : enqueue one entry (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   rdata      : current head entry
//   full/empty : occupancy flags
//   count      : number of entries held
module store_fifo #(
    parameter  int WIDTH = 68,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/store_unit.sv
// Store execution stage: SB/SH/SW with EA = rs + sext(imm16), byte-lane
// generation, misalignment rejection, and a FIFO store buffer draining to
// data memory.
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : instruction handshake (in_ready = !full && !reset)
//   instruction       : [31:26] opcode, [15:0] imm16
//   Read_data1/2      : rs (base), rt (store data)
//   mem               : store request bus (master side)
//   exc_misaligned    : one-cycle pulse when a misaligned SH/SW is dropped
//   exc_addr          : EA of the most recent misaligned store
//   count             : entries currently buffered
module store_unit
    import store_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [31:0]       Read_data1,
    input  logic [31:0]       Read_data2,
    store_unit_if.master      mem,
    output logic              exc_misaligned,
    output logic [ADDR_W-1:0] exc_addr,
    output logic [CNT_W-1:0]  count
);
    localparam int ENTRY_W = ADDR_W + 36;

    logic [31:0]        imm_ext;
    logic [31:0]        ea;
    logic [31:0]        word_addr;
    acc_e               acc;
    logic               misaligned;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic               fire;
    logic               push;
    logic               drop;
    logic [67:0]        entry_full;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               unused_bits;

    assign unused_bits = ^instruction[25:16];

    sign_extend u_sext (
        .imm (instruction[15:0]),
        .ext (imm_ext)
    );

    assign ea = Read_data1 + imm_ext;

    always_comb begin
        case (instruction[31:26])
            OP_SB:   acc = ACC_BYTE;
            OP_SH:   acc = ACC_HALF;
            OP_SW:   acc = ACC_WORD;
            default: acc = ACC_NONE;
        endcase
    end

    // Lane placement is little-endian: byte k of the word sits in wdata[8k+7:8k].
    always_comb begin
        misaligned = 1'b0;
        be         = BE_BYTE << ea[1:0];
        wdata      = {4{Read_data2[7:0]}};
        case (acc)
            ACC_HALF: begin
                misaligned = ea[0];
                be         = ea[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata      = {2{Read_data2[15:0]}};
            end
            ACC_WORD: begin
                misaligned = (ea[1:0] != 2'b00);
                be         = BE_WORD;
                wdata      = Read_data2;
            end
            default: ;
        endcase
    end

    assign fire      = in_valid && in_ready;
    assign push      = fire && (acc != ACC_NONE) && !misaligned;
    assign drop      = fire && (acc != ACC_NONE) && misaligned;
    assign word_addr = {ea[31:2], 2'b00};
    assign entry_full = pack_entry(word_addr, wdata, be);
    assign entry_in   = entry_full[ENTRY_W-1:0];

    store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (mem.mem_valid && mem.mem_ready),
        .wdata (entry_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // No full-bypass: a pop in the same cycle does not reopen the input.
    assign in_ready      = !full && !reset;
    assign mem.mem_valid = !empty;
    assign mem.mem_addr  = empty ? '0 : head[ENTRY_W-1:36];
    assign mem.mem_wdata = empty ? '0 : head[35:4];
    assign mem.mem_be    = empty ? '0 : head[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_misaligned <= 1'b0;
            exc_addr       <= '0;
        end else begin
            exc_misaligned <= drop;
            if (drop) exc_addr <= ea[ADDR_W-1:0];
        end
    end
endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int W      = ADDR_W + 36;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic              exc_misaligned;
    logic [ADDR_W-1:0] exc_addr;
    logic [CNT_W-1:0]  count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0]      exp_q[$];
    logic              m_exc;
    logic [ADDR_W-1:0] m_exc_addr;

    store_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

    store_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction    (instruction),
        .Read_data1     (rd1),
        .Read_data2     (rd2),
        .mem            (mem_bus),
        .exc_misaligned (exc_misaligned),
        .exc_addr       (exc_addr),
        .count          (count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    // Model of one instruction: effective address and lane rules straight from the ISA.
    task automatic model_accept(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] ea;
        logic [31:0] waddr;
        logic [3:0]  be;
        int          k;
        ea    = rs + {{16{instr[15]}}, instr[15:0]};
        waddr = ea & 32'hFFFF_FFFC;
        case (instr[31:26])
            6'h28: begin
                k  = int'(ea[1:0]);
                be = 4'(1 << k);
                exp_q.push_back({waddr, {4{rt[7:0]}}, be});
            end
            6'h29: begin
                if (ea % 2 != 0) begin
                    m_exc = 1'b1; m_exc_addr = ea;
                end else begin
                    be = (ea % 4 == 2) ? 4'b1100 : 4'b0011;
                    exp_q.push_back({waddr, {2{rt[15:0]}}, be});
                end
            end
            6'h2B: begin
                if (ea % 4 != 0) begin
                    m_exc = 1'b1; m_exc_addr = ea;
                end else begin
                    exp_q.push_back({waddr, rt, 4'b1111});
                end
            end
            default: ;
        endcase
    endtask

    // Drive one cycle, advance the model, check every output after the edge.
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic rdy);
        logic [W-1:0] head;
        reset = rst; in_valid = v; instruction = instr; rd1 = rs; rd2 = rt;
        mem_bus.mem_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, W'(in_ready), W'(!rst && exp_q.size() < DEPTH));
        if (rst) begin
            exp_q.delete();
            m_exc = 1'b0;
            m_exc_addr = '0;
        end else begin
            logic accept;
            accept = v && (exp_q.size() < DEPTH);
            m_exc = 1'b0;
            if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
            if (accept) model_accept(instr, rs, rt);
        end
        @(posedge clk);
        #1;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk({tag, ".count"},     W'(count),              W'(exp_q.size()));
        chk({tag, ".mem_valid"}, W'(mem_bus.mem_valid),  W'(exp_q.size() > 0));
        chk({tag, ".mem_addr"},  W'(mem_bus.mem_addr),   W'(head[W-1:36]));
        chk({tag, ".mem_wdata"}, W'(mem_bus.mem_wdata),  W'(head[35:4]));
        chk({tag, ".mem_be"},    W'(mem_bus.mem_be),     W'(head[3:0]));
        chk({tag, ".exc"},       W'(exc_misaligned),     W'(m_exc));
        chk({tag, ".exc_addr"},  W'(exc_addr),           W'(m_exc_addr));
    endtask

    initial begin
        logic [5:0] ops [5];
        reset = 1'b1; in_valid = 1'b0; instruction = '0; rd1 = '0; rd2 = '0;
        mem_bus.mem_ready = 1'b0;
        m_exc = 1'b0; m_exc_addr = '0;
        ops[0] = 6'h28; ops[1] = 6'h29; ops[2] = 6'h2B; ops[3] = 6'h23; ops[4] = 6'h00;

        // Reset state
        step("rst0", 1, 0, '0, '0, '0, 0);
        step("rst1", 1, 1, mk_instr(6'h2B, 16'h0), '0, '0, 1);
        step("idle", 0, 0, '0, '0, '0, 0);

        // 1: SW, next cycle visible, then popped
        step("t1_push", 0, 1, mk_instr(6'h2B, 16'h0004), 32'h1000, 32'hDEADBEEF, 1);
        chk("t1_addr", W'(mem_bus.mem_addr), W'(32'h1004));
        chk("t1_be", W'(mem_bus.mem_be), W'(4'b1111));
        chk("t1_wdata", W'(mem_bus.mem_wdata), W'(32'hDEADBEEF));
        step("t1_pop", 0, 0, '0, '0, '0, 1);
        chk("t1_count0", W'(count), W'(0));

        // 2: SB with negative offset
        step("t2_push", 0, 1, mk_instr(6'h28, 16'hFFFF), 32'h2000, 32'h000000A5, 0);
        chk("t2_addr", W'(mem_bus.mem_addr), W'(32'h1FFC));
        chk("t2_be", W'(mem_bus.mem_be), W'(4'b1000));
        chk("t2_wdata", W'(mem_bus.mem_wdata), W'(32'hA5A5A5A5));
        step("t2_pop", 0, 0, '0, '0, '0, 1);

        // 3: misaligned SH
        step("t3_sh", 0, 1, mk_instr(6'h29, 16'h0000), 32'h3001, 32'h1234, 1);
        chk("t3_exc", W'(exc_misaligned), W'(1));
        chk("t3_exc_addr", W'(exc_addr), W'(32'h3001));
        step("t3_after", 0, 0, '0, '0, '0, 1);
        chk("t3_pulse_end", W'(exc_misaligned), W'(0));

        // 4: fill with stalled memory, then drain in order
        for (int i = 0; i < DEPTH; i++)
            step("t4_fill", 0, 1, mk_instr(6'h2B, 16'(i * 4)), 32'h4000, 32'hA000_0000 + i, 0);
        step("t4_full", 0, 1, mk_instr(6'h2B, 16'h0040), 32'h4000, 32'hBAD0BAD0, 0);
        step("t4_stall", 0, 0, '0, '0, '0, 0);
        for (int i = 0; i < DEPTH + 1; i++)
            step("t4_drain", 0, 0, '0, '0, '0, 1);

        // 5: concurrent push/pop at count 2, then reset mid-drain
        step("t5_a", 0, 1, mk_instr(6'h28, 16'h0001), 32'h5000, 32'h11, 0);
        step("t5_b", 0, 1, mk_instr(6'h29, 16'h0002), 32'h5000, 32'h2222, 0);
        step("t5_pp", 0, 1, mk_instr(6'h2B, 16'h0008), 32'h5000, 32'h33333333, 1);
        chk("t5_count2", W'(count), W'(2));
        step("t5_rst", 1, 0, '0, '0, '0, 1);
        chk("t5_rst_count", W'(count), W'(0));
        step("t5_post", 0, 0, '0, '0, '0, 1);

        // 6: non-store opcode is swallowed silently
        step("t6_lw", 0, 1, mk_instr(6'h23, 16'h0001), 32'h6001, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 4)];
            if (op == 6'h00) op = 6'($urandom);
            step("rnd", ($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                 mk_instr(op, 16'($urandom)), $urandom, $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
